// File: rtl/fifo_arbiter_if.sv
// Valid/ready data-transfer channel shared by the arbiter's requester inputs and its output.
// The producer drives valid/data and the consumer drives ready.
interface dti #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter merging NUM requester channels into one registered output stage.
// When PKT_LOCK is set, the grant is held for a whole packet (eot = payload MSB).
module fifo_arbiter #(
  parameter int NUM      = 4,
  parameter int DIN      = 16,
  parameter int PKT_LOCK = 1
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din [NUM],
  dti.producer dout
);
  localparam int IW = $clog2(NUM);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [NUM-1:0]    in_valid;
  logic [NUM-1:0]    in_ready;
  logic [DIN-1:0]    in_data [NUM];

  logic              out_valid_q, out_valid_d;
  logic [IW+DIN-1:0] out_data_q, out_data_d;
  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     lock_idx_q, lock_idx_d;

  logic              out_ready;
  logic              any_valid;
  logic              xfer;
  logic              eot;
  logic [IW-1:0]     rr_grant;
  logic              rr_found;
  logic [IW:0]       rr_sum;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     grant_inc;
  logic [DIN-1:0]    grant_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_ch
      assign in_valid[gi]  = din[gi].valid;
      assign in_data[gi]   = din[gi].data;
      assign din[gi].ready = in_ready[gi];
      assign in_ready[gi]  = out_ready & (grant == IW'(gi)) & ((state_q == ST_LOCK) | any_valid);
    end
  endgenerate

  assign out_ready = !out_valid_q | dout.ready;
  assign any_valid = |in_valid;

  // Search upward from ptr; the sum is one bit wider so the wrap also works for NUM not a power of two.
  always_comb begin
    rr_grant = ptr_q;
    rr_found = 1'b0;
    rr_sum   = '0;
    for (int k = 0; k < NUM; k++) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NUM)) begin
        rr_sum = rr_sum - (IW+1)'(NUM);
      end
      if (!rr_found && in_valid[rr_sum[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_grant = rr_sum[IW-1:0];
      end
    end
  end

  assign grant      = (state_q == ST_LOCK) ? lock_idx_q : rr_grant;
  assign grant_data = in_data[grant];
  assign xfer       = |(in_valid & in_ready);
  assign eot        = (PKT_LOCK != 0) ? grant_data[DIN-1] : 1'b1;
  assign grant_inc  = (grant == IW'(NUM-1)) ? '0 : grant + 1'b1;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_idx_d  = lock_idx_q;

    if (out_ready) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = {grant, grant_data};
      end
    end

    // An unfinished packet pins the grant; the pointer only advances once a packet closes.
    if (xfer) begin
      if (eot) begin
        state_d = ST_ARB;
        ptr_d   = grant_inc;
      end else begin
        state_d    = ST_LOCK;
        lock_idx_d = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      lock_idx_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign dout.valid = out_valid_q;
  assign dout.data  = out_data_q;
endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: three configurations (4ch locked, 3ch unlocked, 2ch locked) checked
// every cycle against a transaction-level arbitration model, plus directed scenarios.
module tb_fifo_arbiter;
  typedef struct {
    bit          full;
    logic [18:0] word;
    int          owner;
    int          rr;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  v  [3];
  logic [15:0] d  [3][4];
  logic        dr [3];
  mstate_t     ms [3];

  dti #(.W(16)) a_in [4] ();
  dti #(.W(18)) a_out ();
  dti #(.W(16)) b_in [3] ();
  dti #(.W(18)) b_out ();
  dti #(.W(16)) c_in [2] ();
  dti #(.W(17)) c_out ();

  wire [3:0] a_r;
  wire [2:0] b_r;
  wire [1:0] c_r;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_a
      assign a_in[gi].valid = v[0][gi];
      assign a_in[gi].data  = d[0][gi];
      assign a_r[gi]        = a_in[gi].ready;
    end
    for (gi = 0; gi < 3; gi++) begin : g_b
      assign b_in[gi].valid = v[1][gi];
      assign b_in[gi].data  = d[1][gi];
      assign b_r[gi]        = b_in[gi].ready;
    end
    for (gi = 0; gi < 2; gi++) begin : g_c
      assign c_in[gi].valid = v[2][gi];
      assign c_in[gi].data  = d[2][gi];
      assign c_r[gi]        = c_in[gi].ready;
    end
  endgenerate

  assign a_out.ready = dr[0];
  assign b_out.ready = dr[1];
  assign c_out.ready = dr[2];

  fifo_arbiter #(.NUM(4), .DIN(16), .PKT_LOCK(1)) dut_a (.clk(clk), .rst(rst), .din(a_in), .dout(a_out));
  fifo_arbiter #(.NUM(3), .DIN(16), .PKT_LOCK(0)) dut_b (.clk(clk), .rst(rst), .din(b_in), .dout(b_out));
  fifo_arbiter #(.NUM(2), .DIN(16), .PKT_LOCK(1)) dut_c (.clk(clk), .rst(rst), .din(c_in), .dout(c_out));

  function automatic int nch(int k);
    return (k == 0) ? 4 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic bit lk(int k);
    return (k != 1);
  endfunction

  function automatic logic [3:0] obs_r(int k);
    case (k)
      0:       return a_r;
      1:       return {1'b0, b_r};
      default: return {2'b00, c_r};
    endcase
  endfunction

  function automatic logic obs_v(int k);
    case (k)
      0:       return a_out.valid;
      1:       return b_out.valid;
      default: return c_out.valid;
    endcase
  endfunction

  function automatic logic [18:0] obs_d(int k);
    case (k)
      0:       return {1'b0, a_out.data};
      1:       return {1'b0, b_out.data};
      default: return {2'b00, c_out.data};
    endcase
  endfunction

  function automatic logic [18:0] obs_idx(int k);
    return obs_d(k) >> 16;
  endfunction

  // Model: who would be served this cycle (lock owner, else first valid from the rr point).
  function automatic int m_grant(mstate_t s, int k);
    int n = nch(k);
    if (s.owner >= 0) return s.owner;
    for (int j = 0; j < n; j++) begin
      int c = (s.rr + j) % n;
      if (v[k][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int k);
    int g   = m_grant(ms[k], k);
    bit ord = !ms[k].full || dr[k];
    if (g >= 0 && ord) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) ms[k] = '{full: 1'b0, word: '0, owner: -1, rr: 0};
  endtask

  task automatic m_edge(int k);
    int          g   = m_grant(ms[k], k);
    bit          ord = !ms[k].full || dr[k];
    bit          x   = 1'b0;
    bit          e;
    logic [15:0] gd;
    if (g >= 0) x = ord && v[k][g];
    if (ord) ms[k].full = x;
    if (x) begin
      gd          = d[k][g];
      ms[k].word  = (19'(g) << 16) | 19'(gd);
      e           = lk(k) ? gd[15] : 1'b1;
      if (e) begin
        ms[k].owner = -1;
        ms[k].rr    = (g + 1) % nch(k);
      end else begin
        ms[k].owner = g;
      end
    end
  endtask

  task automatic chk(string tag, logic [18:0] obs, logic [18:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare all three DUTs against the model, advance one clock, then update the model.
  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ready[%0d]", k), 19'(obs_r(k)), 19'(exp_ready(k)));
      chk($sformatf("valid[%0d]", k), 19'(obs_v(k)), 19'(ms[k].full));
      if (ms[k].full) chk($sformatf("data[%0d]", k), obs_d(k), ms[k].word);
    end
    @(posedge clk);
    if (!rst) m_reset();
    else for (int k = 0; k < 3; k++) m_edge(k);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      v[k]  = 4'b0000;
      dr[k] = 1'b1;
      for (int c = 0; c < 4; c++) d[k][c] = 16'h0000;
    end
    m_reset();
    rst = 1'b0;
    #1;
    chk("reset_valid_a", 19'(obs_v(0)), 19'd0);
    chk("reset_valid_b", 19'(obs_v(1)), 19'd0);
    chk("reset_valid_c", 19'(obs_v(2)), 19'd0);
    @(posedge clk); #1;
    tick();
    rst = 1'b1;

    // Packet lock on the 4-channel DUT: a lone ch0 beat moves the pointer to 1 on the first edge.
    v[0] = 4'b0001; d[0][0] = 16'h8A00;
    tick();
    chk("first_edge_valid", 19'(obs_v(0)), 19'd1);
    chk("first_edge_data", obs_d(0), 19'h00_8A00);
    v[0] = 4'b1111;
    d[0][0] = 16'h8A01; d[0][1] = 16'h0B01; d[0][2] = 16'h8C01; d[0][3] = 16'h8D01;
    tick();
    chk("pkt_beat1", obs_d(0), 19'h1_0B01);
    d[0][1] = 16'h0B02;
    tick();
    chk("pkt_beat2", obs_d(0), 19'h1_0B02);
    d[0][1] = 16'h8B03;
    tick();
    chk("pkt_beat3", obs_d(0), 19'h1_8B03);
    tick();
    chk("after_pkt_idx", obs_idx(0), 19'd2);
    v[0] = 4'b0000;
    tick();
    tick();
    chk("drain_valid", 19'(obs_v(0)), 19'd0);

    // Backpressure on the 2-channel DUT: held beat stays put, inputs see no ready.
    v[2] = 4'b0011; d[2][0] = 16'h8001; d[2][1] = 16'h8002;
    tick();
    dr[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data", obs_d(2), 19'h0_8001);
      chk("hold_ready", 19'(obs_r(2)), 19'd0);
    end
    dr[2] = 1'b1;
    tick();
    chk("resume_data", obs_d(2), 19'h1_8002);
    v[2] = 4'b0000;
    tick();
    tick();

    // Wrap on the 3-channel DUT: steer ptr to 2, then ch2/ch0 alternate through the wrap.
    v[1] = 4'b0010; d[1][1] = 16'h1111;
    tick();
    v[1] = 4'b0101; d[1][0] = 16'h2000; d[1][2] = 16'h2002;
    tick();
    chk("wrap_idx_a", obs_idx(1), 19'd2);
    tick();
    chk("wrap_idx_b", obs_idx(1), 19'd0);
    tick();
    chk("wrap_idx_c", obs_idx(1), 19'd2);
    v[1] = 4'b0111; d[1][1] = 16'h2001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_seq", obs_idx(1), 19'(i % 3));
    end
    v[1] = 4'b0000;
    tick();
    tick();

    // Asynchronous reset in the middle of a ch3 packet.
    v[0] = 4'b1000; d[0][3] = 16'h0D10;
    tick();
    d[0][3] = 16'h0D11;
    tick();
    chk("pre_rst_valid", 19'(obs_v(0)), 19'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 19'(obs_v(0)), 19'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    v[0] = 4'b1001; d[0][0] = 16'h8E00; d[0][3] = 16'h8E03;
    #1;
    chk("post_rst_ready", 19'(obs_r(0)), 19'b0001);
    tick();
    chk("post_rst_idx", obs_idx(0), 19'd0);
    v[0] = 4'b0000;
    tick();
    tick();

    // Random traffic on all three DUTs against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        v[k]  = 4'($urandom_range(0, 15)) & 4'((1 << nch(k)) - 1);
        dr[k] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 4; c++) d[k][c] = {($urandom_range(0, 2) == 0), 15'($urandom)};
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      v[k]  = 4'b0000;
      dr[k] = 1'b1;
    end
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter NUM, default 4, meaning number of requester channels; legal range 2..8.
REQ-002 SHALL have parameter DIN, default 16, meaning data width per requester including the eot flag.
REQ-003 SHALL have parameter PKT_LOCK, default 1: when 1, din bit DIN-1 is eot and the grant is held for a whole packet; when 0, every beat is arbitrated independently.
REQ-004 SHALL have localparam IW = $clog2(NUM).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port din[NUM], dti.consumer, DIN bits each: requester channels; din[i].ready is driven by this block.
REQ-008 SHALL have port dout, dti.producer, DIN+IW bits: data is {index[IW-1:0], payload[DIN-1:0]}, feeding the shared FIFO.

Function
REQ-009 SHALL register the output in a single stage holding out_valid and out_data; dout.valid = out_valid, dout.data = out_data.
REQ-010 SHALL define out_ready = !out_valid | dout.ready, and load the output register only when out_ready is 1.
REQ-011 SHALL keep out_valid and out_data unchanged while out_valid=1 and dout.ready=0.
REQ-012 SHALL have two states: ARB (unlocked) and LOCK (mid-packet, holding lock_idx).
REQ-013 In ARB, grant SHALL be the first i with din[i].valid=1, searching round-robin from ptr upward, modulo NUM.
REQ-014 In LOCK, grant SHALL be lock_idx, regardless of other valids.
REQ-015 din[i].ready SHALL be out_ready & (i == grant) & (state==LOCK | any valid); all other channels SHALL see ready=0.
REQ-016 A transfer on channel g (din[g].valid & din[g].ready) SHALL load out_data = {g, din[g].data} and set out_valid=1 on the next edge.
REQ-017 If out_ready=1 and no transfer occurs, out_valid SHALL become 0 on the next edge.
REQ-018 On a transfer from g in ARB with PKT_LOCK=1 and eot=0: go to LOCK, lock_idx=g, ptr unchanged.
REQ-019 On a transfer with eot=1, or with PKT_LOCK=0: ptr SHALL become (g+1) mod NUM and the state SHALL be ARB; from LOCK this releases the lock.
REQ-020 A transfer in LOCK with eot=0 SHALL stay in LOCK.
REQ-021 In LOCK with din[lock_idx].valid=0, no other channel SHALL be granted; the output drains per REQ-017.
REQ-022 The ptr increment SHALL wrap with NUM not a power of two (e.g. NUM=3: 2 -> 0); lock_idx and ptr SHALL never exceed NUM-1.
REQ-023 Latency SHALL be 1 cycle from input handshake to dout.valid; throughput SHALL be 1 beat/cycle when dout.ready is held at 1.
REQ-024 dout.valid SHALL never depend combinationally on dout.ready; din[i].ready MAY depend on din valids and dout.ready.
REQ-025 Payload (including eot) SHALL be passed unmodified.

Reset
REQ-026 While rst=0, and immediately without a clock edge: out_valid=0, state=ARB, ptr=0, lock_idx=0; out_data value is don't-care.
REQ-027 Reset asserted mid-packet SHALL discard the lock and the held beat; after release, arbitration SHALL start from ptr=0.
REQ-028 The first rising clk edge after rst goes 1 SHALL be able to perform a transfer.

Verification
REQ-029 NUM=4, PKT_LOCK=0, all four valid continuously, dout.ready=1 -> dout index sequence 0,1,2,3,0,1..., one beat per cycle after 1-cycle latency.
REQ-030 NUM=4, PKT_LOCK=1, ch1 sends a 3-beat packet (eot on beat 3) while ch0, ch2 and ch3 are valid -> three consecutive ch1 beats with no interleaving, then the next grant is ch2.
REQ-031 NUM=2, dout.ready=0 for 5 cycles with both channels valid -> one beat held stable in dout; both din ready=0 after the first load; no beat lost or duplicated after ready returns.
REQ-032 NUM=3, ptr=2, only ch2 and ch0 valid -> ch2 granted, then ch0 (wrap), then ch2.
REQ-033 rst pulsed low asynchronously mid-packet on ch3 -> dout.valid drops at once; after release, with ch0 and ch3 valid, ch0 is granted first.
REQ-034 Random valid/ready traffic with a scoreboard -> per-channel order is preserved, every beat appears exactly once with the correct index, and packets are never interleaved when PKT_LOCK=1.
